pwm_tone_meter: RTL and testbench

//  Receive-side counterpart of the PWM tone generator: measures an external

---
 rtl/pwm_tone_meter.sv | 189 ++++++++++++++++++
 tb/tb_pwm_tone_meter.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/pwm_tone_meter.sv
// Measures an external square/PWM wave and decodes it into the frequency (Hz) and
// 10-bit duty codes the tone generator takes. One shared restoring divider serves both.
module pwm_tone_meter #(
   parameter int unsigned CLK_HZ     = 100_000_000,
   parameter int unsigned TIMEOUT    = 5_000_000,
   parameter int unsigned MIN_PERIOD = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        pwm_in,
   output logic [31:0] freq,
   output logic [9:0]  duty,
   output logic        valid,
   output logic        no_signal,
   output logic        busy
);

   typedef enum logic [2:0] {
      WAIT_FIRST,
      MEASURE,
      DIV_FREQ,
      DIV_DUTY,
      DONE,
      SILENT
   } state_t;

   state_t state_reg, state_next;

   logic        sync1_reg, sync2_reg, level_reg, rise_reg, fall_reg;
   logic [31:0] per_cnt_reg, hi_cnt_reg;
   logic [31:0] p_reg, h_reg, rem_reg, quo_reg;
   logic [9:0]  dq_reg;
   logic [5:0]  iter_reg;
   logic [31:0] freq_reg;
   logic [9:0]  duty_reg;
   logic        valid_reg, no_signal_reg;

   logic        capture, load_result, load_silent;
   logic [32:0] trial;
   logic [31:0] diff;
   logic        take;

   // Rise/fall pulses are registered so they appear three clocks after the pin moves.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync1_reg <= 1'b0;
         sync2_reg <= 1'b0;
         level_reg <= 1'b0;
         rise_reg  <= 1'b0;
         fall_reg  <= 1'b0;
      end else begin
         sync1_reg <= pwm_in;
         sync2_reg <= sync1_reg;
         level_reg <= sync2_reg;
         rise_reg  <= sync2_reg & ~level_reg;
         fall_reg  <= ~sync2_reg & level_reg;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         per_cnt_reg <= '0;
         hi_cnt_reg  <= '0;
      end else begin
         if (rise_reg)
            per_cnt_reg <= 32'd1;
         else if (per_cnt_reg < TIMEOUT)
            per_cnt_reg <= per_cnt_reg + 32'd1;

         if (rise_reg)
            hi_cnt_reg <= 32'd1;
         else if (level_reg && !fall_reg && hi_cnt_reg != '1)
            hi_cnt_reg <= hi_cnt_reg + 32'd1;
      end
   end

   // The quotient bit fed into the trial remainder is the dividend MSB for freq, 0 for duty.
   always_comb begin
      trial = (state_reg == DIV_FREQ) ? {rem_reg, quo_reg[31]} : {rem_reg, 1'b0};
      take  = (trial >= {1'b0, p_reg});
      diff  = trial[31:0] - p_reg;
   end

   always_comb begin
      state_next  = state_reg;
      capture     = 1'b0;
      load_result = 1'b0;
      load_silent = 1'b0;
      case (state_reg)
         WAIT_FIRST: begin
            if (rise_reg)
               state_next = MEASURE;
         end
         MEASURE: begin
            if (rise_reg) begin
               if (per_cnt_reg >= MIN_PERIOD) begin
                  state_next = DIV_FREQ;
                  capture    = 1'b1;
               end
            end else if (per_cnt_reg >= TIMEOUT) begin
               state_next  = SILENT;
               load_silent = 1'b1;
            end
         end
         DIV_FREQ: begin
            if (iter_reg == 6'd31)
               state_next = DIV_DUTY;
         end
         DIV_DUTY: begin
            if (iter_reg == 6'd9)
               state_next = DONE;
         end
         DONE: begin
            state_next  = MEASURE;
            load_result = 1'b1;
         end
         SILENT: begin
            if (rise_reg)
               state_next = MEASURE;
         end
         default: state_next = WAIT_FIRST;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         state_reg <= WAIT_FIRST;
      else
         state_reg <= state_next;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         p_reg    <= '0;
         h_reg    <= '0;
         rem_reg  <= '0;
         quo_reg  <= '0;
         dq_reg   <= '0;
         iter_reg <= '0;
      end else if (capture) begin
         p_reg    <= per_cnt_reg;
         h_reg    <= hi_cnt_reg;
         rem_reg  <= '0;
         quo_reg  <= CLK_HZ;
         iter_reg <= '0;
      end else if (state_reg == DIV_FREQ) begin
         quo_reg <= {quo_reg[30:0], take};
         if (iter_reg == 6'd31) begin
            // Duty divide starts from the high count; H < P so it fits the remainder.
            rem_reg  <= h_reg;
            iter_reg <= '0;
         end else begin
            rem_reg  <= take ? diff : trial[31:0];
            iter_reg <= iter_reg + 6'd1;
         end
      end else if (state_reg == DIV_DUTY) begin
         rem_reg  <= take ? diff : trial[31:0];
         dq_reg   <= {dq_reg[8:0], take};
         iter_reg <= (iter_reg == 6'd9) ? 6'd0 : iter_reg + 6'd1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         freq_reg      <= '0;
         duty_reg      <= '0;
         valid_reg     <= 1'b0;
         no_signal_reg <= 1'b1;
      end else begin
         valid_reg <= load_result | load_silent;
         if (load_result) begin
            freq_reg      <= quo_reg;
            duty_reg      <= dq_reg;
            no_signal_reg <= 1'b0;
         end else if (load_silent) begin
            freq_reg      <= '0;
            duty_reg      <= '0;
            no_signal_reg <= 1'b1;
         end
      end
   end

   assign freq      = freq_reg;
   assign duty      = duty_reg;
   assign valid     = valid_reg;
   assign no_signal = no_signal_reg;
   assign busy      = (state_reg == DIV_FREQ) || (state_reg == DIV_DUTY) || (state_reg == DONE);

endmodule

// File: tb/tb_pwm_tone_meter.sv
// Directed bench for pwm_tone_meter: a pin-level model predicts each valid pulse and a
// scoreboard compares freq/duty/no_signal and latency when the DUT reports.
module tb_pwm_tone_meter;
   localparam int unsigned CLK_HZ     = 1_000_000;
   localparam int unsigned TIMEOUT    = 5000;
   localparam int unsigned MIN_PERIOD = 4;
   localparam int          LATENCY    = 47;

   logic        clk = 1'b0;
   logic        rst;
   logic        pwm_in;
   logic [31:0] freq;
   logic [9:0]  duty;
   logic        valid, no_signal, busy;

   int checks   = 0;
   int failures = 0;
   int edge_cnt = 0;
   int n_valid  = 0;

   typedef struct {
      logic [31:0] freq;
      logic [9:0]  duty;
      logic        ns;
      int          stamp;
   } exp_t;
   exp_t sb[$];

   typedef enum {M_WAIT, M_MEAS, M_SIL} mmode_t;
   mmode_t m_mode;
   logic   m_prev;
   longint m_per, m_hi;
   int     m_busy;

   pwm_tone_meter #(
      .CLK_HZ(CLK_HZ),
      .TIMEOUT(TIMEOUT),
      .MIN_PERIOD(MIN_PERIOD)
   ) dut (
      .clk(clk),
      .rst(rst),
      .pwm_in(pwm_in),
      .freq(freq),
      .duty(duty),
      .valid(valid),
      .no_signal(no_signal),
      .busy(busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) edge_cnt <= edge_cnt + 1;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_mode = M_WAIT;
      m_prev = 1'b0;
      m_per  = 0;
      m_hi   = 0;
      m_busy = 0;
      sb.delete();
   endtask

   // Drive one pin cycle (called at a falling edge) and update the reference model.
   task automatic step(input logic v);
      exp_t e;
      pwm_in = v;
      if (v && !m_prev) begin
         if (m_busy == 0) begin
            if (m_mode == M_MEAS) begin
               if (m_per >= MIN_PERIOD) begin
                  e.freq  = 32'(longint'(CLK_HZ) / m_per);
                  e.duty  = 10'((m_hi * 1024) / m_per);
                  e.ns    = 1'b0;
                  e.stamp = edge_cnt;
                  sb.push_back(e);
                  m_busy = 44;
               end
            end else begin
               m_mode = M_MEAS;
            end
         end
         m_per = 1;
         m_hi  = 1;
      end else begin
         if (m_per < TIMEOUT) m_per++;
         if (v) m_hi++;
         if (m_mode == M_MEAS && m_busy == 0 && m_per >= TIMEOUT) begin
            e.freq  = '0;
            e.duty  = '0;
            e.ns    = 1'b1;
            e.stamp = -1;
            sb.push_back(e);
            m_mode = M_SIL;
         end
      end
      if (m_busy > 0) m_busy--;
      m_prev = v;
      @(negedge clk);
   endtask

   task automatic tone(input int period, input int high, input int n);
      for (int k = 0; k < n; k++) begin
         for (int i = 0; i < high; i++) step(1'b1);
         for (int i = 0; i < period - high; i++) step(1'b0);
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0);
   endtask

   always @(negedge clk) begin
      if (rst === 1'b1 && valid === 1'b1) begin
         n_valid++;
         if (sb.size() == 0) begin
            check("valid_unexpected", 64'(valid), 64'd0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("freq", 64'(freq), 64'(e.freq));
            check("duty", 64'(duty), 64'(e.duty));
            check("no_signal", 64'(no_signal), 64'(e.ns));
            if (e.stamp >= 0)
               check("latency", 64'(edge_cnt - e.stamp), 64'(LATENCY));
            $display("valid #%0d at edge %0d: freq=%0d duty=%0d no_signal=%0b",
                     n_valid, edge_cnt, freq, duty, no_signal);
         end
      end
   end

   initial begin
      rst    = 1'b1;
      pwm_in = 1'b0;
      model_reset();
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("rst_freq", 64'(freq), 64'd0);
      check("rst_duty", 64'(duty), 64'd0);
      check("rst_valid", 64'(valid), 64'd0);
      check("rst_no_signal", 64'(no_signal), 64'd1);
      check("rst_busy", 64'(busy), 64'd0);
      idle(3);
      rst = 1'b1;
      idle(5);

      tone(1000, 500, 3);      // freq 1000, duty 512
      tone(2500, 625, 3);      // freq 400, duty 256
      tone(2273, 1136, 3);     // freq 439, duty 511 (truncation)
      for (int i = 0; i < 30; i++) begin
         step(1'b1);
         step(1'b0);
         step(1'b0);
      end
      tone(1000, 250, 3);      // after glitch burst: duty 256
      tone(4, 2, 20);          // period exactly MIN_PERIOD is accepted
      tone(1000, 500, 3);

      idle(2 * TIMEOUT);
      check("silent_no_signal", 64'(no_signal), 64'd1);
      check("silent_freq", 64'(freq), 64'd0);
      check("silent_duty", 64'(duty), 64'd0);
      tone(1000, 500, 3);
      check("resume_no_signal", 64'(no_signal), 64'd0);

      // Reset in the middle of a divide.
      for (int i = 0; i < 10; i++) step(1'b1);
      check("busy_during_div", 64'(busy), 64'd1);
      rst = 1'b0;
      #1;
      model_reset();
      check("midrst_freq", 64'(freq), 64'd0);
      check("midrst_duty", 64'(duty), 64'd0);
      check("midrst_valid", 64'(valid), 64'd0);
      check("midrst_no_signal", 64'(no_signal), 64'd1);
      check("midrst_busy", 64'(busy), 64'd0);
      idle(5);
      rst = 1'b1;
      idle(5);
      tone(1000, 500, 3);
      check("after_rst_no_signal", 64'(no_signal), 64'd0);
      check("after_rst_freq", 64'(freq), 64'd1000);

      idle(200);
      check("scoreboard_drained", 64'(sb.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
